// File: rtl/xgmii_split_64b32b.sv
// xgmii_split_64b32b
// ------------------
// Transmit-path width converter. Buffers 64-bit XGMII words in a small FIFO and
// emits them as a continuous 32-bit XGMII stream, low half first, one half per
// `tick`. Idle is inserted between frames. If a frame starves mid-way, an error
// half is emitted and the rest of that frame is discarded up to its terminate.
//
// Ports:
//   clk        single clock
//   rst        asynchronous, active-high reset
//   tick       output slot strobe (one half emitted per tick)
//   xgmii64    input word {data[63:0], ctrl[7:0], ena}; ena is the write strobe
//   xgmii32    registered output half {data[31:0], ctrl[3:0], ena}
//   level      FIFO occupancy (AW+1 bits)
//   overflow   sticky: an input word was dropped because the FIFO was full
//   underrun   sticky: a frame starved mid-way
//   frame_cnt  frames completed (live only with XGMII_SPLIT_STATS_EN)
//   err_cnt    underrun events  (live only with XGMII_SPLIT_STATS_EN)
//
// Build option: define XGMII_SPLIT_STATS_EN to compile the 16-bit wrapping
// frame/error counters; otherwise both counter ports are tied to zero.

package xgmii_split_pkg;
  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  ctrl;
    logic        ena;
  } xgmii64_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  ctrl;
    logic        ena;
  } xgmii32_t;
endpackage

module xgmii_split_64b32b
  import xgmii_split_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  xgmii64_t      xgmii64,
  output xgmii32_t      xgmii32,
  output logic [AW:0]   level,
  output logic          overflow,
  output logic          underrun,
  output logic [15:0]   frame_cnt,
  output logic [15:0]   err_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FRAME = 2'd1;
  localparam logic [1:0] S_DROP  = 2'd2;

  localparam logic [31:0] IDLE_DATA = 32'h0707_0707;
  localparam logic [31:0] ERR_DATA  = 32'hFEFE_FEFE;

  // FIFO storage: entry = {ctrl[7:0], data[63:0]}
  logic [71:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          hsel_q, hsel_d;
  logic [1:0]    state_q, state_d;
  logic          overflow_q, overflow_d, underrun_q, underrun_d;
  logic [31:0]   out_data_q, out_data_d;
  logic [3:0]    out_ctrl_q, out_ctrl_d;
  logic          out_ena_q;

  logic          empty, full, wr_en, pop, consume;
  logic          frame_inc, err_inc;
  logic [71:0]   rd_word;
  logic [31:0]   half_data;
  logic [3:0]    half_ctrl;
  logic          has_start, has_term;

  assign empty = (level_q == '0);
  assign full  = (level_q == (AW+1)'(DEPTH));

  // Selected half of the head entry and its start/terminate decode.
  // NOTE: every always_comb output is given a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    rd_word   = mem_q[rd_ptr_q];
    half_data = hsel_q ? rd_word[63:32] : rd_word[31:0];
    half_ctrl = hsel_q ? rd_word[71:68] : rd_word[67:64];
    has_start = 1'b0;
    has_term  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (half_ctrl[i] && half_data[8*i +: 8] == 8'hFB) has_start = 1'b1;
      if (half_ctrl[i] && half_data[8*i +: 8] == 8'hFD) has_term  = 1'b1;
    end
  end

  // Read side: frame state machine, output half selection, consumption.
  always_comb begin
    state_d    = state_q;
    hsel_d     = hsel_q;
    underrun_d = underrun_q;
    out_data_d = out_data_q;
    out_ctrl_d = out_ctrl_q;
    consume    = 1'b0;
    pop        = 1'b0;
    frame_inc  = 1'b0;
    err_inc    = 1'b0;

    if (tick) begin
      case (state_q)
        S_IDLE: begin
          if (!empty) begin
            out_data_d = half_data;
            out_ctrl_d = half_ctrl;
            consume    = 1'b1;
            // A start with its terminate in the same half is a complete frame.
            if (has_start && !has_term) state_d = S_FRAME;
          end else begin
            out_data_d = IDLE_DATA;
            out_ctrl_d = 4'hF;
          end
        end
        S_FRAME: begin
          if (!empty) begin
            out_data_d = half_data;
            out_ctrl_d = half_ctrl;
            consume    = 1'b1;
            if (has_term) begin
              state_d   = S_IDLE;
              frame_inc = 1'b1;
            end
          end else begin
            out_data_d = ERR_DATA;
            out_ctrl_d = 4'hF;
            underrun_d = 1'b1;
            err_inc    = 1'b1;
            state_d    = S_DROP;
          end
        end
        S_DROP: begin
          // Late halves of the broken frame are swallowed; the link sees idle.
          out_data_d = IDLE_DATA;
          out_ctrl_d = 4'hF;
          if (!empty) begin
            consume = 1'b1;
            if (has_term) state_d = S_IDLE;
          end
        end
        default: begin
          out_data_d = IDLE_DATA;
          out_ctrl_d = 4'hF;
          state_d    = S_IDLE;
        end
      endcase
    end

    // The entry leaves the FIFO only once its high half has been used.
    if (consume) begin
      hsel_d = ~hsel_q;
      pop    = hsel_q;
    end
  end

  // Write side: a simultaneous pop frees the slot, so a full FIFO still accepts.
  always_comb begin
    wr_en      = xgmii64.ena && (!full || pop);
    overflow_d = overflow_q | (xgmii64.ena & ~wr_en);
    wr_ptr_d   = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop   ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({wr_en, pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      hsel_q     <= 1'b0;
      state_q    <= S_IDLE;
      overflow_q <= 1'b0;
      underrun_q <= 1'b0;
      out_data_q <= IDLE_DATA;
      out_ctrl_q <= 4'hF;
      out_ena_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      hsel_q     <= hsel_d;
      state_q    <= state_d;
      overflow_q <= overflow_d;
      underrun_q <= underrun_d;
      out_data_q <= out_data_d;
      out_ctrl_q <= out_ctrl_d;
      out_ena_q  <= tick;
    end
  end

  // NOTE: the storage array has no reset; resetting the pointers and level is
  // enough to discard its contents, and it keeps the array mappable to RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {xgmii64.ctrl, xgmii64.data};
  end

  assign xgmii32  = '{data: out_data_q, ctrl: out_ctrl_q, ena: out_ena_q};
  assign level    = level_q;
  assign overflow = overflow_q;
  assign underrun = underrun_q;

`ifdef XGMII_SPLIT_STATS_EN
  logic [15:0] frame_cnt_q, frame_cnt_d, err_cnt_q, err_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q + {15'd0, frame_inc};
    err_cnt_d   = err_cnt_q   + {15'd0, err_inc};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;
`else
  logic unused_stats;
  assign unused_stats = frame_inc ^ err_inc;
  assign frame_cnt    = '0;
  assign err_cnt      = '0;
`endif

endmodule

// File: tb/tb_xgmii_split_64b32b.sv
// Self-checking bench for xgmii_split_64b32b. Expected non-idle output halves
// are queued as stimulus is driven and compared in order as the DUT emits them;
// idle halves (07070707/F) are counted separately.
module tb_xgmii_split_64b32b;
  import xgmii_split_pkg::*;

  localparam int DEPTH = 8;
  localparam int AW    = $clog2(DEPTH);
`ifdef XGMII_SPLIT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam logic [31:0] IDLE_D = 32'h0707_0707;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick;
  xgmii64_t    xgmii64;
  xgmii32_t    xgmii32;
  logic [AW:0] level;
  logic        overflow, underrun;
  logic [15:0] frame_cnt, err_cnt;

  xgmii_split_64b32b #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .tick(tick), .xgmii64(xgmii64), .xgmii32(xgmii32),
    .level(level), .overflow(overflow), .underrun(underrun),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int idle_seen = 0;
  logic [35:0] exp_q[$];   // {ctrl[3:0], data[31:0]}

  function automatic logic [15:0] cnt_exp(input int n);
    return STATS ? 16'(n) : 16'd0;
  endfunction

  // Scoreboard monitor: one sample per output slot, 1 time unit after the edge.
  always @(posedge clk) begin
    #1;
    if (!rst && xgmii32.ena) begin
      if (xgmii32.data == IDLE_D && xgmii32.ctrl == 4'hF) begin
        idle_seen++;
      end else begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected got %h/%h, nothing expected", xgmii32.data, xgmii32.ctrl);
        end else begin
          logic [35:0] e;
          e = exp_q.pop_front();
          if ({xgmii32.ctrl, xgmii32.data} !== e) begin
            errors++;
            $display("FAIL sb_half got %h/%h expected %h/%h",
                     xgmii32.data, xgmii32.ctrl, e[31:0], e[35:32]);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_half(input logic [31:0] d, input logic [3:0] c);
    if (!(d == IDLE_D && c == 4'hF)) exp_q.push_back({c, d});
  endtask

  task automatic push_word(input logic [63:0] d, input logic [7:0] c);
    push_half(d[31:0], c[3:0]);
    push_half(d[63:32], c[7:4]);
  endtask

  // One word every second cycle.
  task automatic send_word(input logic [63:0] d, input logic [7:0] c, input bit exp);
    xgmii64 = '{data: d, ctrl: c, ena: 1'b1};
    if (exp) push_word(d, c);
    step();
    xgmii64.ena = 1'b0;
    step();
  endtask

  function automatic logic [63:0] data_word(input int seed);
    return {32'(seed * 2 + 1) ^ 32'h1234_0000, 32'(seed * 2) ^ 32'h5678_0000};
  endfunction

  localparam logic [63:0] TERM_D = {40'h07_0707_0707, 8'hFD, 16'hBEEF};
  localparam logic [7:0]  TERM_C = 8'hFC;
  localparam logic [63:0] SOF0_D = 64'hD555_5555_5555_55FB;

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0 && level == 0) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    step();
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick = 1'b0;
    xgmii64 = '0;
    step();
    step();
    checks++; if (xgmii32 !== '{data: IDLE_D, ctrl: 4'hF, ena: 1'b0}) begin errors++;
      $display("FAIL rst_out got %h/%h/%b expected 07070707/f/0", xgmii32.data, xgmii32.ctrl, xgmii32.ena); end
    checks++; if (level !== '0) begin errors++; $display("FAIL rst_level got %0d expected 0", level); end
    checks++; if ({overflow, underrun} !== 2'b00) begin errors++;
      $display("FAIL rst_flags got %b%b expected 00", overflow, underrun); end
    checks++; if ({frame_cnt, err_cnt} !== 32'd0) begin errors++;
      $display("FAIL rst_cnt got %h/%h expected 0/0", frame_cnt, err_cnt); end
    rst = 1'b0;
    tick = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (xgmii32 !== '{data: IDLE_D, ctrl: 4'hF, ena: 1'b1}) begin errors++;
        $display("FAIL idle_%0d got %h/%h/%b expected 07070707/f/1", i, xgmii32.data, xgmii32.ctrl, xgmii32.ena); end
    end
    checks++; if ({overflow, underrun} !== 2'b00) begin errors++;
      $display("FAIL idle_flags got %b%b expected 00", overflow, underrun); end
  endtask

  task automatic test_lane0_frame();
    bit ok;
    send_word(SOF0_D, 8'h01, 1'b1);
    for (int i = 0; i < 8; i++) send_word(data_word(i), 8'h00, 1'b1);
    send_word(TERM_D, TERM_C, 1'b1);
    wait_drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL lane0_drain left %0d halves level %0d", exp_q.size(), level); end
    checks++; if (level !== '0) begin errors++; $display("FAIL lane0_level got %0d expected 0", level); end
    checks++; if (frame_cnt !== cnt_exp(1)) begin errors++;
      $display("FAIL lane0_frames got %0d expected %0d", frame_cnt, cnt_exp(1)); end
  endtask

  task automatic test_lane4_start();
    bit ok;
    send_word({32'h5555_55FB, IDLE_D}, 8'h1F, 1'b1);
    for (int i = 20; i < 24; i++) send_word(data_word(i), 8'h00, 1'b1);
    send_word(TERM_D, TERM_C, 1'b1);
    wait_drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL lane4_drain left %0d halves level %0d", exp_q.size(), level); end
    checks++; if (frame_cnt !== cnt_exp(2)) begin errors++;
      $display("FAIL lane4_frames got %0d expected %0d", frame_cnt, cnt_exp(2)); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL lane4_underrun got %b expected 0", underrun); end
  endtask

  task automatic test_underrun();
    bit ok;
    send_word(SOF0_D, 8'h01, 1'b1);
    send_word(data_word(40), 8'h00, 1'b1);
    send_word(data_word(41), 8'h00, 1'b1);
    push_half(32'hFEFE_FEFE, 4'hF);
    for (int i = 0; i < 6; i++) step();
    // Late remainder of the broken frame: all consumed silently.
    for (int i = 42; i < 47; i++) send_word(data_word(i), 8'h00, 1'b0);
    send_word(TERM_D, TERM_C, 1'b0);
    wait_drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL ur_drain left %0d halves level %0d", exp_q.size(), level); end
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL ur_flag got %b expected 1", underrun); end
    checks++; if (err_cnt !== cnt_exp(1)) begin errors++;
      $display("FAIL ur_errcnt got %0d expected %0d", err_cnt, cnt_exp(1)); end
    checks++; if (frame_cnt !== cnt_exp(2)) begin errors++;
      $display("FAIL ur_frames_dropped got %0d expected %0d", frame_cnt, cnt_exp(2)); end
    // The next frame passes normally.
    send_word(SOF0_D, 8'h01, 1'b1);
    for (int i = 60; i < 63; i++) send_word(data_word(i), 8'h00, 1'b1);
    send_word(TERM_D, TERM_C, 1'b1);
    wait_drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL ur_next_drain left %0d halves", exp_q.size()); end
    checks++; if (frame_cnt !== cnt_exp(3)) begin errors++;
      $display("FAIL ur_next_frames got %0d expected %0d", frame_cnt, cnt_exp(3)); end
  endtask

  task automatic test_overflow();
    bit ok;
    tick = 1'b0;
    step();
    for (int i = 0; i < DEPTH + 2; i++) begin
      xgmii64 = '{data: {32'hC000_0000 | 32'(2*i+1), 32'hC000_0000 | 32'(2*i)}, ctrl: 8'h00, ena: 1'b1};
      if (i < DEPTH) push_word(xgmii64.data, xgmii64.ctrl);
      step();
    end
    xgmii64.ena = 1'b0;
    step();
    checks++; if (level !== (AW+1)'(DEPTH)) begin errors++;
      $display("FAIL ovf_level got %0d expected %0d", level, DEPTH); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b expected 1", overflow); end
    tick = 1'b1;
    wait_drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL ovf_drain left %0d halves level %0d", exp_q.size(), level); end
  endtask

  task automatic test_full_rw_reset();
    rst = 1'b1;
    tick = 1'b0;
    step();
    rst = 1'b0;
    step();
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 0) begin
        xgmii64 = '{data: SOF0_D, ctrl: 8'h01, ena: 1'b1};
        push_word(SOF0_D, 8'h01);
      end else begin
        xgmii64 = '{data: data_word(80 + i), ctrl: 8'h00, ena: 1'b1};
      end
      step();
    end
    xgmii64.ena = 1'b0;
    step();
    checks++; if (level !== (AW+1)'(DEPTH)) begin errors++;
      $display("FAIL full_level got %0d expected %0d", level, DEPTH); end
    tick = 1'b1;
    step();                                   // low half of the start word
    xgmii64 = '{data: data_word(99), ctrl: 8'h00, ena: 1'b1};
    step();                                   // high half popped, write accepted
    xgmii64.ena = 1'b0;
    checks++; if (level !== (AW+1)'(DEPTH)) begin errors++;
      $display("FAIL rw_level got %0d expected %0d", level, DEPTH); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rw_overflow got %b expected 0", overflow); end
    // Mid-frame asynchronous reset, away from any clock edge.
    #2;
    rst = 1'b1;
    #1;
    checks++; if (xgmii32 !== '{data: IDLE_D, ctrl: 4'hF, ena: 1'b0}) begin errors++;
      $display("FAIL arst_out got %h/%h/%b expected 07070707/f/0", xgmii32.data, xgmii32.ctrl, xgmii32.ena); end
    checks++; if (level !== '0) begin errors++; $display("FAIL arst_level got %0d expected 0", level); end
    checks++; if ({overflow, underrun, frame_cnt, err_cnt} !== 34'd0) begin errors++;
      $display("FAIL arst_stat got %b%b %h %h expected all 0", overflow, underrun, frame_cnt, err_cnt); end
    step();
    rst = 1'b0;
    step();
    checks++; if (xgmii32 !== '{data: IDLE_D, ctrl: 4'hF, ena: 1'b1}) begin errors++;
      $display("FAIL arst_first got %h/%h/%b expected 07070707/f/1", xgmii32.data, xgmii32.ctrl, xgmii32.ena); end
    step();
    checks++; if (exp_q.size() != 0) begin errors++;
      $display("FAIL arst_sb got %0d halves pending expected 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_lane0_frame();
    test_lane4_start();
    test_underrun();
    test_overflow();
    test_full_rw_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout reached before the summary");
    $fatal(1, "timeout");
  end

endmodule
